bounce_generator: RTL

BOUNCE_GENERATOR -- requirements
Module: bounce_generator

---
 rtl/bounce_gen_pkg.sv | 28 ++
 rtl/bounce_generator_lfsr16.sv | 38 +++
 rtl/bounce_generator.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/bounce_gen_pkg.sv
// -----------------------------------------------------------------------------
// bounce_gen_pkg
// Shared definitions for the bounce generator: controller state encoding,
// LFSR geometry and feedback taps, counter widths and the LFSR feedback helper.
// -----------------------------------------------------------------------------
package bounce_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int LFSR_W = 16;

    // Fibonacci taps 16,14,13,11 on a right-shifting register map to
    // register bits 0,2,3,5; the XOR of those bits enters at the MSB.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    localparam int TOG_W = 5;
    localparam int GAP_W = 9;

    function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] value);
        return ^(value & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/bounce_generator_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Fibonacci LFSR; it advances on every clock, whatever
// the controller is doing, so the pseudo-random sequence depends only on the
// number of clocks since reset.
// Ports:
//   i_Clk    in   clock, rising edge
//   i_Rst_L  in   asynchronous active-low reset, loads SEED
//   o_Value  out  current register contents
// -----------------------------------------------------------------------------
module lfsr16
    import bounce_gen_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    output logic [LFSR_W-1:0] o_Value
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_feedback(lfsr_q), lfsr_q[LFSR_W-1:1]};
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_Value = lfsr_q;

endmodule

// File: rtl/bounce_generator.sv
// -----------------------------------------------------------------------------
// bounce_generator
// Emulates a mechanical switch: on request the output line toggles an odd,
// pseudo-random number of times with pseudo-random gaps, finishing at the
// requested level, then holds steady for a settle period before reporting
// completion.
// Ports:
//   i_Clk     in   clock, rising edge
//   i_Rst_L   in   asynchronous active-low reset
//   i_Req     in   single-cycle request, accepted only in IDLE
//   i_Level   in   target level, sampled with i_Req
//   o_Switch  out  emulated bouncing switch line (registered)
//   o_Busy    out  high whenever the controller is not IDLE (registered)
//   o_Done    out  one-cycle completion pulse (registered)
// -----------------------------------------------------------------------------
module bounce_generator
    import bounce_gen_pkg::*;
#(
    parameter int                CLKS_PER_TICK = 25,
    parameter int                MAX_BOUNCES   = 8,
    parameter int                MAX_GAP_TICKS = 64,
    parameter int                SETTLE_TICKS  = 100,
    parameter logic [LFSR_W-1:0] SEED          = 16'hACE1
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Req,
    input  logic i_Level,
    output logic o_Switch,
    output logic o_Busy,
    output logic o_Done
);

    localparam int PRE_W = $clog2(CLKS_PER_TICK + 1);
    localparam int SET_W = $clog2(SETTLE_TICKS + 1);

    localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(CLKS_PER_TICK - 1);
    localparam logic [3:0]       BOUNCE_MASK = 4'(MAX_BOUNCES - 1);
    localparam logic [7:0]       GAP_MASK    = 8'(MAX_GAP_TICKS - 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_TICKS);

    state_e             state_q,      state_d;
    logic [TOG_W-1:0]   tog_cnt_q,    tog_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q,    gap_cnt_d;
    logic [PRE_W-1:0]   presc_q,      presc_d;
    logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic               switch_q,     switch_d;
    logic               busy_q,       busy_d;
    logic               done_q,       done_d;

    logic [LFSR_W-1:0]  lfsr_val;
    logic [3:0]         bounce_n;
    logic [GAP_W-1:0]   gap_load;
    logic               tick;
    logic               toggle_now;
    logic               lfsr_unused;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .o_Value (lfsr_val)
    );

    // Bits [7:4] of the LFSR are not part of either random draw.
    assign lfsr_unused = ^lfsr_val[7:4];

    assign bounce_n = lfsr_val[3:0] & BOUNCE_MASK;
    assign gap_load = GAP_W'(lfsr_val[15:8] & GAP_MASK) + GAP_W'(1);
    assign tick     = (presc_q == PRE_LAST);

    always_comb begin
        state_d      = state_q;
        tog_cnt_d    = tog_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        settle_cnt_d = settle_cnt_q;
        switch_d     = switch_q;
        presc_d      = tick ? '0 : presc_q + PRE_W'(1);
        toggle_now   = 1'b0;

        unique case (state_q)
            IDLE: begin
                presc_d = '0;
                if (i_Req) begin
                    if (i_Level == switch_q) begin
                        state_d = DONE;
                    end else begin
                        state_d   = BOUNCE;
                        // 2N+1 toggles always lands on the opposite level.
                        tog_cnt_d = {bounce_n, 1'b1};
                        gap_cnt_d = '0;
                    end
                end
            end

            BOUNCE: begin
                // A zero gap only occurs on the first BOUNCE cycle, giving the
                // one-clock request-to-toggle latency. Afterwards the toggle
                // fires on the last clock of the final gap tick so toggles are
                // exactly G ticks apart.
                toggle_now = (gap_cnt_q == '0) ||
                             (tick && (gap_cnt_q == GAP_W'(1)));
                if (toggle_now) begin
                    switch_d  = ~switch_q;
                    tog_cnt_d = tog_cnt_q - TOG_W'(1);
                    presc_d   = '0;
                    if (tog_cnt_q == TOG_W'(1)) begin
                        state_d      = SETTLE;
                        settle_cnt_d = SETTLE_LOAD;
                        gap_cnt_d    = '0;
                    end else begin
                        gap_cnt_d = gap_load;
                    end
                end else if (tick) begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            SETTLE: begin
                if (tick) begin
                    if (settle_cnt_q == SET_W'(1)) begin
                        state_d      = DONE;
                        settle_cnt_d = '0;
                    end else begin
                        settle_cnt_d = settle_cnt_q - SET_W'(1);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Tick boundaries are aligned to every state entry.
        if (state_d != state_q) begin
            presc_d = '0;
        end

        // Outputs are registered from the next state so they line up with it.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q      <= IDLE;
            tog_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            presc_q      <= '0;
            settle_cnt_q <= '0;
            switch_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tog_cnt_q    <= tog_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            presc_q      <= presc_d;
            settle_cnt_q <= settle_cnt_d;
            switch_q     <= switch_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign o_Switch = switch_q;
    assign o_Busy   = busy_q;
    assign o_Done   = done_q;

endmodule
